rtmc_ctrl_multi: RTL and testbench
==================================

Name: rtmc_ctrl_multi

Overview:
Next-generation motor controller. Drives N_CH independent stepper channels from one register bus. Each channel has its own phase table, step-rate counter, signed position counter and direction-aware soft limits. Adds a counted MOVE mode with a sticky done flag and interrupt, and modulo phase-index wrap. Sits between the SPI/register bridge and the motor driver pins.

Parameters:
N_CH, 2, number of motor channels (power of 2, 1..4)
ADDR_W, 8, register address width
DATA_W, 16, register data width
MC_W, 4, phase outputs per channel
MC_DEPTH, 8, phase-table entries per channel (power of 2)
CNT_W, 32, width of the delay, position, remain and limit counters (=2*DATA_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reg_addr  in  ADDR_W  {.., ch[CH_B-1:0] at bit 5, tbl_sel bit 4, offset[3:0]}
reg_wdat  in  DATA_W  write data
reg_wr  in  1  write strobe, held until reg_ack
reg_rd  in  1  read strobe, held until reg_ack
reg_rdat  out  DATA_W  read data, valid while reg_ack=1
reg_ack  out  1  one-cycle acknowledge
mc  out  N_CH*MC_W  phase outputs; channel c at [c*MC_W +: MC_W]
mc_oe  out  N_CH*MC_W  phase output enables
done_irq  out  N_CH  level, = sticky done flag of each channel

Behaviour:
- Reset, synchronous, active-high: reg_ack=0, reg_rdat=0, mc_oe=0, done_irq=0. All channels go to IDLE with idx=0, delay=0, pos=0, remain=0, step_delay=0, ctrl=0. limit_pos=2^(CNT_W-1)-1 and limit_neg=-2^(CNT_W-1). Table contents are undefined. mc equals table[0].
- Bus: reg_ack <= (reg_wr|reg_rd) & ~reg_ack. The write or read is performed once, in the cycle the strobe is sampled with reg_ack=0. Read data is registered and valid with ack.
- tbl_sel=1: table[ch][offset mod MC_DEPTH], MC_W bits, read/write.
- Per-channel offsets (hi word = bits 31:16):
  - 0 ID: reads 0x0242, write ignored.
  - 1 CTRL: [15] run, [14] step, [13] move; table_last at [7:4], step_size signed at [3:0].
  - 2 STAT (RO): [10] done, [9] limit_flag, [8] limit_blk, [5:4] state, [3:0] idx. Writing any value clears done and limit_flag.
  - 3 OE: [MC_W-1:0].
  - 4/5 STEP_DELAY hi/lo.
  - 6/7 POS hi/lo: read; a write clears the counter to 0.
  - 8/9 REMAIN hi/lo: write loads, ignored while in MOVE.
  - 10/11 LIMIT_POS hi/lo.
  - 12/13 LIMIT_NEG hi/lo.
  - 14/15: read 0xEEEE, write ignored.
- State encoding: IDLE=0, RUN=1, MOVE=2.
  - IDLE->RUN on CTRL write with run=1.
  - IDLE->MOVE on CTRL write with move=1 and run=0 and remain!=0.
  - move=1 with remain=0: set done, stay IDLE.
  - RUN/MOVE->IDLE on CTRL write with run=move=0, or on a blocked step.
  - MOVE->IDLE after the step that decrements remain to 0; set done on that step.
  - A CTRL write of run/move while already busy updates step_size/table_last only; state is unchanged.
- Step timing: in RUN/MOVE, tick = (delay==0). On tick, delay<=step_delay; otherwise delay-1. delay is forced to 0 in IDLE. The first step lands in the 1st busy cycle; the step period is step_delay+1 cycles.
- Single step: CTRL write with step=1 in IDLE performs one step the next cycle, subject to the limit. It is ignored while busy.
- Step allowed if size>0 & pos<limit_pos, or size<0 & pos>limit_neg, or size==0. limit_blk = combinational not-allowed. A blocked tick sets limit_flag and forces IDLE. Stepping away from a limit is always allowed.
- On an allowed step:
  - pos += sext(size).
  - idx <= (idx+size) modulo (table_last+1), computed in CH width+1 signed. |size|<=table_last+1 is required of software.
  - If in MOVE, remain -= 1.
- Simultaneous events: POS write clear beats a step in the same cycle. Reset beats everything. mc = table[idx], combinational from the registered idx.

Decomposition:
- Package rtmc_pkg: offset localparams, ID value, state enum (2 bits), CH_B=$clog2(N_CH), ERR_DATA=16'hEEEE.
- Sub-module rtmc_chan: one channel's registers, table, FSM and counters, with a local write/read port.
- Top: address decode, N_CH rtmc_chan instances via generate, read mux, ack.

Test Plan:
- Reset then read ch0 off0 and ch1 off0 -> 0x0242 each; reg_ack high exactly 1 cycle per access; mc_oe=0.
- ch0: table[0..3]=1,2,4,8, step_delay=3, CTRL run=1, last=3, size=+1 -> mc0 sequence 1,2,4,8,1, each held 4 cycles; POS increments; ch1 mc unchanged.
- ch1: REMAIN=5, CTRL move=1, size=-1, last=3 -> idx 0,3,2,1,0,3, returns to IDLE; POS=-5; done_irq[1]=1 until a STAT write.
- LIMIT_POS=2, RUN size=+1 -> stops at POS=2, limit_flag=1. Then RUN size=-1 -> steps proceed.
- While running, write POS -> POS reads 0 then continues. CTRL run=0 -> IDLE next cycle, idx frozen.
- Assert rst mid-MOVE -> next cycle: IDLE, POS=0, done=0, mc_oe=0.

Source files
------------

// File: rtl/rtmc_pkg.sv
// Shared register map, state encoding and helpers for the multi-channel stepper controller.
package rtmc_pkg;

  localparam logic [3:0] OFF_ID     = 4'd0;
  localparam logic [3:0] OFF_CTRL   = 4'd1;
  localparam logic [3:0] OFF_STAT   = 4'd2;
  localparam logic [3:0] OFF_OE     = 4'd3;
  localparam logic [3:0] OFF_SD_HI  = 4'd4;
  localparam logic [3:0] OFF_SD_LO  = 4'd5;
  localparam logic [3:0] OFF_POS_HI = 4'd6;
  localparam logic [3:0] OFF_POS_LO = 4'd7;
  localparam logic [3:0] OFF_REM_HI = 4'd8;
  localparam logic [3:0] OFF_REM_LO = 4'd9;
  localparam logic [3:0] OFF_LP_HI  = 4'd10;
  localparam logic [3:0] OFF_LP_LO  = 4'd11;
  localparam logic [3:0] OFF_LN_HI  = 4'd12;
  localparam logic [3:0] OFF_LN_LO  = 4'd13;

  localparam logic [15:0] ID_VALUE = 16'h0242;
  localparam logic [15:0] ERR_DATA = 16'hEEEE;

  localparam int CH_LSB  = 5;
  localparam int TBL_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MOVE = 2'd2
  } state_t;

  // Channel-select field width; a single-channel build still carries one (ignored) bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtmc_chan.sv
// One stepper channel: phase table, step-rate counter, signed position, soft limits and RUN/MOVE FSM.
module rtmc_chan
  import rtmc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MC_W     = 4,
  parameter int MC_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              tbl_sel,
  input  logic [3:0]        off,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat,
  output logic [MC_W-1:0]   mc,
  output logic [MC_W-1:0]   mc_oe,
  output logic              done
);

  localparam int IDX_W = $clog2(MC_DEPTH);

  state_t                   state_q, state_nxt;
  logic [MC_W-1:0]          tbl [MC_DEPTH];
  logic [IDX_W-1:0]         idx_q, idx_nxt;
  logic [CNT_W-1:0]         delay_q, step_delay_q, remain_q;
  logic signed [CNT_W-1:0]  pos_q, lim_pos_q, lim_neg_q;
  logic [DATA_W-1:0]        ctrl_q;
  logic [MC_W-1:0]          oe_q;
  logic                     done_q, flag_q, step_pend_q;

  logic signed [3:0] size;
  logic [3:0]        last;
  logic reg_wr, tbl_wr, ctrl_wr, pos_wr, busy, tick, stop_wr, allowed, do_step, step_ok;
  logic [6:0] idx_ext, sum, modv, wrapped;

  assign size    = ctrl_q[3:0];
  assign last    = ctrl_q[7:4];
  assign reg_wr  = wr_en & ~tbl_sel;
  assign tbl_wr  = wr_en & tbl_sel;
  assign ctrl_wr = reg_wr & (off == OFF_CTRL);
  assign pos_wr  = reg_wr & ((off == OFF_POS_HI) | (off == OFF_POS_LO));
  assign busy    = (state_q != ST_IDLE);
  assign tick    = busy & (delay_q == '0);
  // A stop command wins over a step that would land in the same cycle.
  assign stop_wr = ctrl_wr & busy & ~wdat[15] & ~wdat[13];
  assign allowed = (size > 4'sd0) ? (pos_q < lim_pos_q) :
                   (size < 4'sd0) ? (pos_q > lim_neg_q) : 1'b1;
  assign do_step = (tick & ~stop_wr) | step_pend_q;
  assign step_ok = do_step & allowed;

  // Phase index wraps modulo table_last+1, including negative steps.
  always_comb begin
    idx_ext = 7'(idx_q);
    modv    = 7'(last) + 7'd1;
    sum     = idx_ext + {{3{size[3]}}, size};
    if (sum[6])            wrapped = sum + modv;
    else if (sum >= modv)  wrapped = sum - modv;
    else                   wrapped = sum;
    idx_nxt = IDX_W'(wrapped);
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr) begin
          if (wdat[15])                          state_nxt = ST_RUN;
          else if (wdat[13] && remain_q != '0)   state_nxt = ST_MOVE;
        end
      end
      ST_RUN, ST_MOVE: begin
        if (stop_wr)                             state_nxt = ST_IDLE;
        else if (do_step && !allowed)            state_nxt = ST_IDLE;
        else if (do_step && state_q == ST_MOVE && remain_q == CNT_W'(1))
                                                 state_nxt = ST_IDLE;
      end
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      delay_q      <= '0;
      pos_q        <= '0;
      remain_q     <= '0;
      step_delay_q <= '0;
      ctrl_q       <= '0;
      oe_q         <= '0;
      lim_pos_q    <= {1'b0, {(CNT_W-1){1'b1}}};
      lim_neg_q    <= {1'b1, {(CNT_W-1){1'b0}}};
      done_q       <= 1'b0;
      flag_q       <= 1'b0;
      step_pend_q  <= 1'b0;
    end else begin
      step_pend_q <= ctrl_wr & ~busy & wdat[14] & ~wdat[15] & ~wdat[13];

      if (!busy)     delay_q <= '0;
      else if (tick) delay_q <= step_delay_q;
      else           delay_q <= delay_q - CNT_W'(1);

      if (ctrl_wr) begin
        if (busy && (wdat[15] || wdat[13])) ctrl_q[7:0] <= wdat[7:0];
        else                                ctrl_q      <= wdat;
        if (!busy && wdat[13] && !wdat[15] && remain_q == '0) done_q <= 1'b1;
      end

      if (reg_wr) begin
        case (off)
          OFF_STAT:   begin done_q <= 1'b0; flag_q <= 1'b0; end
          OFF_OE:     oe_q <= wdat[MC_W-1:0];
          OFF_SD_HI:  step_delay_q[CNT_W-1:DATA_W] <= wdat;
          OFF_SD_LO:  step_delay_q[DATA_W-1:0]     <= wdat;
          OFF_REM_HI: if (state_q != ST_MOVE) remain_q[CNT_W-1:DATA_W] <= wdat;
          OFF_REM_LO: if (state_q != ST_MOVE) remain_q[DATA_W-1:0]     <= wdat;
          OFF_LP_HI:  lim_pos_q[CNT_W-1:DATA_W] <= wdat;
          OFF_LP_LO:  lim_pos_q[DATA_W-1:0]     <= wdat;
          OFF_LN_HI:  lim_neg_q[CNT_W-1:DATA_W] <= wdat;
          OFF_LN_LO:  lim_neg_q[DATA_W-1:0]     <= wdat;
          default: ;
        endcase
      end

      if (pos_wr)       pos_q <= '0;
      else if (step_ok) pos_q <= pos_q + {{(CNT_W-4){size[3]}}, size};

      if (step_ok) begin
        idx_q <= idx_nxt;
        if (state_q == ST_MOVE) begin
          remain_q <= remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) done_q <= 1'b1;
        end
      end
      if (do_step && !allowed) flag_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) tbl[off[IDX_W-1:0]] <= wdat[MC_W-1:0];
  end

  always_comb begin
    rdat = '0;
    if (tbl_sel) begin
      rdat = DATA_W'(tbl[off[IDX_W-1:0]]);
    end else begin
      case (off)
        OFF_ID:     rdat = ID_VALUE;
        OFF_CTRL:   rdat = ctrl_q;
        OFF_STAT:   rdat = {5'd0, done_q, flag_q, ~allowed, 2'd0, state_q, 4'(idx_q)};
        OFF_OE:     rdat = DATA_W'(oe_q);
        OFF_SD_HI:  rdat = step_delay_q[CNT_W-1:DATA_W];
        OFF_SD_LO:  rdat = step_delay_q[DATA_W-1:0];
        OFF_POS_HI: rdat = pos_q[CNT_W-1:DATA_W];
        OFF_POS_LO: rdat = pos_q[DATA_W-1:0];
        OFF_REM_HI: rdat = remain_q[CNT_W-1:DATA_W];
        OFF_REM_LO: rdat = remain_q[DATA_W-1:0];
        OFF_LP_HI:  rdat = lim_pos_q[CNT_W-1:DATA_W];
        OFF_LP_LO:  rdat = lim_pos_q[DATA_W-1:0];
        OFF_LN_HI:  rdat = lim_neg_q[CNT_W-1:DATA_W];
        OFF_LN_LO:  rdat = lim_neg_q[DATA_W-1:0];
        default:    rdat = ERR_DATA;
      endcase
    end
  end

  assign mc    = tbl[idx_q];
  assign mc_oe = oe_q;
  assign done  = done_q;

endmodule

// File: rtl/rtmc_ctrl_multi.sv
// Multi-channel stepper controller top: register-bus decode, one-cycle ack, per-channel instances.
module rtmc_ctrl_multi
  import rtmc_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MC_W     = 4,
  parameter int MC_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      reg_addr,
  input  logic [DATA_W-1:0]      reg_wdat,
  input  logic                   reg_wr,
  input  logic                   reg_rd,
  output logic [DATA_W-1:0]      reg_rdat,
  output logic                   reg_ack,
  output logic [N_CH*MC_W-1:0]   mc,
  output logic [N_CH*MC_W-1:0]   mc_oe,
  output logic [N_CH-1:0]        done_irq
);

  localparam int CH_B = ch_bits(N_CH);

  logic              access_wr, access_rd;
  logic [CH_B-1:0]   ch_sel;
  logic [DATA_W-1:0] ch_rdat [N_CH];
  logic              unused_addr;

  // A held strobe is serviced once: only while ack is low.
  assign access_wr   = reg_wr & ~reg_ack;
  assign access_rd   = reg_rd & ~reg_ack;
  assign ch_sel      = (N_CH > 1) ? reg_addr[CH_LSB +: CH_B] : '0;
  assign unused_addr = ^reg_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_ack  <= 1'b0;
      reg_rdat <= '0;
    end else begin
      reg_ack <= (reg_wr | reg_rd) & ~reg_ack;
      if (access_rd) reg_rdat <= ch_rdat[ch_sel];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    rtmc_chan #(
      .DATA_W   (DATA_W),
      .MC_W     (MC_W),
      .MC_DEPTH (MC_DEPTH),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (access_wr && (ch_sel == CH_B'(c))),
      .tbl_sel (reg_addr[TBL_BIT]),
      .off     (reg_addr[3:0]),
      .wdat    (reg_wdat),
      .rdat    (ch_rdat[c]),
      .mc      (mc[c*MC_W +: MC_W]),
      .mc_oe   (mc_oe[c*MC_W +: MC_W]),
      .done    (done_irq[c])
    );
  end

endmodule

// File: tb/tb_rtmc_ctrl_multi.sv
// Directed bench for rtmc_ctrl_multi: bus access, RUN/MOVE stepping, limits, position clear, reset.
module tb_rtmc_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  reg_addr = '0;
  logic [15:0] reg_wdat = '0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [15:0] reg_rdat;
  logic        reg_ack;
  logic [7:0]  mc, mc_oe;
  logic [1:0]  done_irq;

  int checks = 0;
  int errors = 0;

  rtmc_ctrl_multi dut (
    .clk      (clk),
    .rst      (rst),
    .reg_addr (reg_addr),
    .reg_wdat (reg_wdat),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdat (reg_rdat),
    .reg_ack  (reg_ack),
    .mc       (mc),
    .mc_oe    (mc_oe),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    logic seen;
    seen = 1'b0;
    reg_addr = a; reg_wdat = d; reg_wr = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      seen = reg_ack;
    end
    reg_wr = 1'b0;
    if (!seen) check("wr_ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [15:0] d);
    logic seen;
    seen = 1'b0;
    reg_addr = a; reg_rd = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      seen = reg_ack;
    end
    d = reg_rdat;
    reg_rd = 1'b0;
    if (!seen) check("rd_ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  seq0 [4];
    logic [3:0]  seq1 [5];
    logic [3:0]  tb0  [4];
    logic [3:0]  tb1  [4];
    logic [15:0] d;
    seq0 = '{4'd2, 4'd4, 4'd8, 4'd1};
    seq1 = '{4'd9, 4'd12, 4'd6, 4'd3, 4'd9};
    tb0  = '{4'd1, 4'd2, 4'd4, 4'd8};
    tb1  = '{4'd3, 4'd6, 4'd12, 4'd9};

    // Reset state and ID reads
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", 32'(reg_ack), 32'd0);
    check("rst_rdat", 32'(reg_rdat), 32'd0);
    check("rst_oe", 32'(mc_oe), 32'd0);
    check("rst_done", 32'(done_irq), 32'd0);
    rd_chk("id_ch0", 8'h00, 16'h0242);
    cycles(1);
    check("ack_one_cycle", 32'(reg_ack), 32'd0);
    rd_chk("id_ch1", 8'h20, 16'h0242);
    rd_chk("lim_pos_hi_rst", 8'h0A, 16'h7FFF);
    rd_chk("lim_neg_hi_rst", 8'h0C, 16'h8000);
    rd_chk("lim_neg_lo_rst", 8'h0D, 16'h0000);
    rd_chk("reserved_off", 8'h0E, 16'hEEEE);

    // Phase tables and output enables
    for (int i = 0; i < 4; i++) begin
      bus_wr(8'h10 + 8'(i), 16'(tb0[i]));
      bus_wr(8'h30 + 8'(i), 16'(tb1[i]));
    end
    rd_chk("tbl_rd", 8'h12, 16'h0004);
    rd_chk("tbl_rd_mod", 8'h1A, 16'h0004);
    bus_wr(8'h03, 16'h000F);
    bus_wr(8'h23, 16'h000F);
    check("oe_both", 32'(mc_oe), 32'hFF);

    // ch0 RUN, size +1, period 4 cycles
    bus_wr(8'h05, 16'd3);
    bus_wr(8'h01, 16'h8031);
    check("mc0_start", 32'(mc[3:0]), 32'd1);
    for (int k = 0; k < 16; k++) begin
      cycles(1);
      check("mc0_seq", 32'(mc[3:0]), 32'(seq0[k/4]));
    end
    check("mc1_quiet", 32'(mc[7:4]), 32'd3);
    rd_chk("pos_run", 8'h07, 16'd4);
    bus_wr(8'h01, 16'h0031);
    rd_chk("stat_stop", 8'h02, 16'h0001);
    cycles(10);
    rd_chk("stat_frozen", 8'h02, 16'h0001);
    rd_chk("pos_frozen", 8'h07, 16'd5);

    // ch1 MOVE of 5 steps, size -1
    bus_wr(8'h29, 16'd5);
    bus_wr(8'h21, 16'h203F);
    check("mc1_start", 32'(mc[7:4]), 32'd3);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("mc1_seq", 32'(mc[7:4]), 32'(seq1[k]));
    end
    check("move_done_irq", 32'(done_irq), 32'b10);
    cycles(1);
    check("mc1_hold", 32'(mc[7:4]), 32'd9);
    rd_chk("pos1_lo", 8'h27, 16'hFFFB);
    rd_chk("pos1_hi", 8'h26, 16'hFFFF);
    rd_chk("stat1_done", 8'h22, 16'h0403);
    rd_chk("remain1", 8'h29, 16'h0000);
    bus_wr(8'h22, 16'h0000);
    check("done_cleared", 32'(done_irq), 32'd0);
    rd_chk("stat1_clr", 8'h22, 16'h0003);
    bus_wr(8'h21, 16'h203F);
    check("move0_done", 32'(done_irq), 32'b10);
    rd_chk("stat1_move0", 8'h22, 16'h0403);
    bus_wr(8'h22, 16'h0000);

    // ch0 positive soft limit, then stepping away
    bus_wr(8'h07, 16'h0000);
    rd_chk("pos_clr_idle", 8'h07, 16'd0);
    bus_wr(8'h0A, 16'h0000);
    bus_wr(8'h0B, 16'd2);
    bus_wr(8'h01, 16'h8031);
    cycles(20);
    rd_chk("pos_at_limit", 8'h07, 16'd2);
    rd_chk("stat_limit", 8'h02, 16'h0303);
    bus_wr(8'h05, 16'd99);
    bus_wr(8'h01, 16'h803F);
    rd_chk("pos_away", 8'h07, 16'd1);
    rd_chk("stat_away", 8'h02, 16'h0212);
    bus_wr(8'h06, 16'h0000);
    rd_chk("pos_clr_run", 8'h07, 16'd0);
    cycles(100);
    rd_chk("pos_cont_lo", 8'h07, 16'hFFFF);
    rd_chk("pos_cont_hi", 8'h06, 16'hFFFF);
    bus_wr(8'h01, 16'h003F);
    rd_chk("stat_stop2", 8'h02, 16'h0201);
    cycles(5);
    rd_chk("pos_stop2", 8'h07, 16'hFFFF);
    bus_wr(8'h02, 16'h0000);

    // single step in IDLE
    bus_wr(8'h01, 16'h403F);
    cycles(2);
    rd_chk("pos_single", 8'h07, 16'hFFFE);
    rd_chk("stat_single", 8'h02, 16'h0000);

    // reset in the middle of a MOVE
    bus_wr(8'h29, 16'd50);
    bus_wr(8'h21, 16'h203F);
    cycles(5);
    bus_rd(8'h22, d);
    check("mid_move_state", 32'(d[5:4]), 32'd2);
    check("mid_move_done", 32'(done_irq), 32'd0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst2_ack", 32'(reg_ack), 32'd0);
    check("rst2_rdat", 32'(reg_rdat), 32'd0);
    check("rst2_oe", 32'(mc_oe), 32'd0);
    check("rst2_done", 32'(done_irq), 32'd0);
    check("rst2_mc", 32'(mc), 32'h31);
    rd_chk("rst2_stat1", 8'h22, 16'h0000);
    rd_chk("rst2_pos1", 8'h27, 16'h0000);
    rd_chk("rst2_ctrl1", 8'h21, 16'h0000);
    rd_chk("rst2_lim_pos", 8'h0B, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
